register_alu_engine: RTL and testbench

REGISTER_ALU_ENGINE -- requirements
Module: register_alu_engine

---
 rtl/calc_pkg.sv | 18 +
 rtl/register_alu_engine_if.sv | 25 ++
 rtl/seq_multiplier.sv | 51 +++++
 rtl/register_alu_engine.sv | 132 +++++++++++++
 tb/tb_register_alu_engine.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared opcode constants and control-state encoding for the register ALU engine.
package calc_pkg;

   localparam logic [2:0] OP_INIT  = 3'b000;
   localparam logic [2:0] OP_LOAD  = 3'b001;
   localparam logic [2:0] OP_FETCH = 3'b010;
   localparam logic [2:0] OP_STORE = 3'b011;
   localparam logic [2:0] OP_ADD   = 3'b100;
   localparam logic [2:0] OP_SUB   = 3'b101;
   localparam logic [2:0] OP_MUL   = 3'b110;
   localparam logic [2:0] OP_POW   = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

endpackage

// File: rtl/register_alu_engine_if.sv
// Command/status bundle of the register ALU engine; master issues commands, slave executes.
interface register_alu_engine_if #(
   parameter int WIDTH = 5,
   parameter int NREGS = 4
) ();
   localparam int KW = $clog2(NREGS);

   logic                   perform;
   logic [2:0]             op;
   logic [KW-1:0]          k;
   logic [NREGS*WIDTH-1:0] r;
   logic                   busy;
   logic                   done;
   logic                   overflow;

   modport master (
      output perform, op, k,
      input  r, busy, done, overflow
   );

   modport slave (
      input  perform, op, k,
      output r, busy, done, overflow
   );
endinterface

// File: rtl/seq_multiplier.sv
// Shift-add multiplier: one partial product per edge, WIDTH edges after start; done flags the final edge.
// No backpressure: start is only honoured by the caller when idle; product is combinational on the done edge.
module seq_multiplier #(
   parameter int WIDTH = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] product,
   output logic               done
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_next;
   logic [CW-1:0]      cnt_q;
   logic               run_q;

   // product already includes the partial product added on the final edge
   assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign product  = acc_next;
   assign done     = run_q && (cnt_q == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
      end else if (start) begin
         mcand_q  <= {{WIDTH{1'b0}}, a};
         mplier_q <= b;
         acc_q    <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b1;
      end else if (run_q) begin
         acc_q    <= acc_next;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + CW'(1);
         if (done) begin
            run_q <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/register_alu_engine.sv
// Register-file ALU: single-edge ops complete at accept; multiply completes WIDTH edges after accept.
// Backpressure via busy: commands offered while busy are dropped, not queued.
module register_alu_engine
   import calc_pkg::*;
#(
   parameter int WIDTH = 5,
   parameter int NREGS = 4
) (
   input  logic                  core_clk,
   input  logic                  rst,
   register_alu_engine_if.slave  bus
);
   localparam int KW = $clog2(NREGS);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   regs_q [NREGS];
   logic [WIDTH-1:0]   regs_d [NREGS];
   logic               ovf_q, ovf_d;
   logic               done_q, done_d;
   logic               mul_start;
   logic               mul_last;
   logic [2*WIDTH-1:0] mul_product;
   logic [WIDTH-1:0]   r0;
   logic [WIDTH-1:0]   rk;
   logic [WIDTH:0]     add_res;
   logic [WIDTH:0]     sub_res;
   logic [WIDTH-1:0]   pow_res;
   logic               pow_big;

   assign r0      = regs_q[0];
   assign rk      = regs_q[bus.k];
   assign add_res = {1'b0, r0} + {1'b0, rk};
   assign sub_res = {1'b0, r0} - {1'b0, rk};
   assign pow_big = ({1'b0, rk} >= (WIDTH + 1)'(WIDTH));

   always_comb begin
      pow_res = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pow_res[i] = (rk == WIDTH'(i));
      end
   end

   seq_multiplier #(.WIDTH(WIDTH)) u_mul (
      .clk     (core_clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (r0),
      .b       (rk),
      .product (mul_product),
      .done    (mul_last)
   );

   always_comb begin
      state_d   = state_q;
      regs_d    = regs_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      mul_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.perform) begin
               done_d = 1'b1;
               ovf_d  = 1'b0;
               case (bus.op)
                  OP_INIT: begin
                     for (int i = 0; i < NREGS; i++) begin
                        regs_d[i] = WIDTH'(i);
                     end
                  end
                  OP_LOAD:  regs_d[0] = WIDTH'(bus.k);
                  OP_FETCH: regs_d[0] = rk;
                  OP_STORE: regs_d[bus.k] = r0;
                  OP_ADD: begin
                     regs_d[0] = add_res[WIDTH-1:0];
                     ovf_d     = add_res[WIDTH];
                  end
                  OP_SUB: begin
                     regs_d[0] = sub_res[WIDTH-1:0];
                     ovf_d     = sub_res[WIDTH];
                  end
                  OP_POW: begin
                     regs_d[0] = pow_big ? '0 : pow_res;
                     ovf_d     = pow_big;
                  end
                  default: begin
                     // multiply: status keeps its old value until the product lands
                     done_d    = 1'b0;
                     ovf_d     = ovf_q;
                     mul_start = 1'b1;
                     state_d   = ST_MUL;
                  end
               endcase
            end
         end
         ST_MUL: begin
            if (mul_last) begin
               regs_d[0] = mul_product[WIDTH-1:0];
               ovf_d     = |mul_product[2*WIDTH-1:WIDTH];
               done_d    = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge core_clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   for (genvar g = 0; g < NREGS; g++) begin : g_flat
      assign bus.r[g*WIDTH +: WIDTH] = regs_q[g];
   end

   assign bus.busy     = (state_q == ST_MUL);
   assign bus.done     = done_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_register_alu_engine.sv
// Directed bench: per-cycle vector table plus hand-written multiply and reset-abort sequences.
module tb_register_alu_engine;
   import calc_pkg::*;

   typedef struct {
      logic        rst;
      logic        perform;
      logic [2:0]  op;
      logic [1:0]  k;
      logic [19:0] exp_r;
      logic        exp_busy;
      logic        exp_done;
      logic        exp_ovf;
   } vec_t;

   logic core_clk = 1'b0;
   logic rst      = 1'b1;
   int   n_vec    = 0;
   int   n_err    = 0;
   vec_t vecs [22];

   always #5 core_clk = ~core_clk;

   register_alu_engine_if #(.WIDTH(5), .NREGS(4)) bus ();

   register_alu_engine #(.WIDTH(5), .NREGS(4)) dut (
      .core_clk (core_clk),
      .rst      (rst),
      .bus      (bus)
   );

   function automatic logic [19:0] pk(input int r3, input int r2, input int r1, input int r0);
      return {5'(r3), 5'(r2), 5'(r1), 5'(r0)};
   endfunction

   function automatic vec_t v(input logic rs, input logic pf, input logic [2:0] op, input int k,
                              input logic [19:0] r, input logic b, input logic d, input logic o);
      vec_t t;
      t.rst = rs; t.perform = pf; t.op = op; t.k = 2'(k);
      t.exp_r = r; t.exp_busy = b; t.exp_done = d; t.exp_ovf = o;
      return t;
   endfunction

   task automatic tick();
      @(posedge core_clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cmd(input logic [2:0] op, input int k);
      bus.perform = 1'b1;
      bus.op      = op;
      bus.k       = 2'(k);
      tick();
      bus.perform = 1'b0;
   endtask

   int busy_cnt;
   int cyc;
   logic any_done;
   logic any_r;

   initial begin
      bus.perform = 1'b0;
      bus.op      = OP_INIT;
      bus.k       = '0;

      vecs[0]  = v(1, 0, OP_INIT,  0, pk(0,0,0,0),  0, 0, 0);
      vecs[1]  = v(0, 1, OP_INIT,  0, pk(3,2,1,0),  0, 1, 0);
      vecs[2]  = v(0, 0, OP_INIT,  0, pk(3,2,1,0),  0, 0, 0);
      vecs[3]  = v(0, 1, OP_SUB,   1, pk(3,2,1,31), 0, 1, 1);
      vecs[4]  = v(0, 0, OP_INIT,  0, pk(3,2,1,31), 0, 0, 1);
      vecs[5]  = v(0, 1, OP_INIT,  0, pk(3,2,1,0),  0, 1, 0);
      vecs[6]  = v(0, 1, OP_FETCH, 3, pk(3,2,1,3),  0, 1, 0);
      vecs[7]  = v(0, 1, OP_POW,   0, pk(3,2,1,8),  0, 1, 0);
      vecs[8]  = v(0, 1, OP_STORE, 1, pk(3,2,8,8),  0, 1, 0);
      vecs[9]  = v(0, 1, OP_ADD,   1, pk(3,2,8,16), 0, 1, 0);
      vecs[10] = v(0, 1, OP_ADD,   0, pk(3,2,8,0),  0, 1, 1);
      vecs[11] = v(0, 0, OP_INIT,  0, pk(3,2,8,0),  0, 0, 1);
      vecs[12] = v(0, 1, OP_LOAD,  3, pk(3,2,8,3),  0, 1, 0);
      vecs[13] = v(0, 1, OP_ADD,   2, pk(3,2,8,5),  0, 1, 0);
      vecs[14] = v(0, 1, OP_ADD,   2, pk(3,2,8,7),  0, 1, 0);
      vecs[15] = v(0, 1, OP_STORE, 3, pk(7,2,8,7),  0, 1, 0);
      vecs[16] = v(0, 1, OP_POW,   3, pk(7,2,8,0),  0, 1, 1);
      vecs[17] = v(0, 0, OP_INIT,  0, pk(7,2,8,0),  0, 0, 1);
      vecs[18] = v(0, 1, OP_LOAD,  2, pk(7,2,8,2),  0, 1, 0);
      vecs[19] = v(0, 1, OP_POW,   0, pk(7,2,8,4),  0, 1, 0);
      vecs[20] = v(0, 1, OP_POW,   0, pk(7,2,8,16), 0, 1, 0);
      vecs[21] = v(0, 1, OP_POW,   0, pk(7,2,8,0),  0, 1, 1);

      for (int i = 0; i < 22; i++) begin
         rst         = vecs[i].rst;
         bus.perform = vecs[i].perform;
         bus.op      = vecs[i].op;
         bus.k       = vecs[i].k;
         tick();
         chk($sformatf("vec%0d {r,busy,done,ovf}", i),
             32'({bus.r, bus.busy, bus.done, bus.overflow}),
             32'({vecs[i].exp_r, vecs[i].exp_busy, vecs[i].exp_done, vecs[i].exp_ovf}));
      end
      rst = 1'b0;
      bus.perform = 1'b0;

      // 3*2 multiply; a load offered while busy must vanish
      rst = 1'b1; tick(); rst = 1'b0;
      cmd(OP_INIT, 0);
      cmd(OP_LOAD, 3);
      cmd(OP_MUL, 2);
      chk("mul accept busy/done", 32'({bus.busy, bus.done}), 32'(2'b10));
      busy_cnt = 0;
      cyc = 0;
      bus.perform = 1'b1; bus.op = OP_LOAD; bus.k = 2'd1;
      while (!bus.done && cyc < 20) begin
         if (bus.busy) busy_cnt++;
         if (bus.r[4:0] !== 5'd3) begin
            n_err++;
            $display("FAIL mul R0 during busy: got %0d, expected 3", bus.r[4:0]);
         end
         tick();
         bus.perform = 1'b0;
         cyc++;
      end
      chk("mul done reached within bound", 32'(bus.done), 32'(1));
      chk("mul busy cycles", 32'(busy_cnt), 32'(5));
      chk("mul 3*2 R0", 32'(bus.r[4:0]), 32'(6));
      chk("mul 3*2 busy/ovf", 32'({bus.busy, bus.overflow}), 32'(2'b00));
      cmd(OP_LOAD, 2);
      chk("accept in done cycle R0/done", 32'({bus.r[4:0], bus.done}), 32'({5'd2, 1'b1}));
      tick();
      chk("done single pulse", 32'(bus.done), 32'(0));

      // 16*3 wraps to 16 with overflow
      rst = 1'b1; tick(); rst = 1'b0;
      cmd(OP_INIT, 0);
      cmd(OP_LOAD, 2);
      cmd(OP_POW, 0);
      cmd(OP_POW, 0);
      chk("setup R0=16 R3=3", 32'({bus.r[19:15], bus.r[4:0]}), 32'({5'd3, 5'd16}));
      cmd(OP_MUL, 3);
      cyc = 0;
      while (!bus.done && cyc < 20) begin
         tick();
         cyc++;
      end
      chk("mul 16*3 R0/ovf/done", 32'({bus.r[4:0], bus.overflow, bus.done}),
          32'({5'd16, 1'b1, 1'b1}));
      tick();

      // reset two edges into a multiply aborts it
      cmd(OP_MUL, 3);
      tick();
      rst = 1'b1; tick(); rst = 1'b0;
      chk("abort R/busy/done/ovf", 32'({bus.r, bus.busy, bus.done, bus.overflow}), 32'(0));
      any_done = 1'b0;
      any_r    = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         any_done |= bus.done;
         any_r    |= (bus.r != '0);
      end
      chk("abort no later done", 32'(any_done), 32'(0));
      chk("abort no later R write", 32'(any_r), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
